// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one fixed-latency single-port SRAM between the IF and
//               MEM pipeline requesters and freezes the pipeline until both
//               requests of the current pipeline cycle have been served.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES = 4,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic [31:0]            if_rdata,
    output logic                   if_ready,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic [31:0]            mem_rdata,
    output logic                   mem_ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [31:0]            sram_dq_out,
    input  logic [31:0]            sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [3:0] c_cnt_load  = 4'(WAIT_CYCLES - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [3:0]             r_cnt;
    logic                   r_if_done;
    logic                   r_mem_done;
    logic                   r_grant_mem;
    logic                   r_is_write;
    logic [31:0]            r_if_rdata;
    logic [31:0]            r_mem_rdata;
    logic                   r_if_ready;
    logic                   r_mem_ready;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic [31:0]            r_sram_dq_out;
    logic                   r_sram_we_n;
    logic                   r_sram_oe_n;

    logic                   w_if_pend;
    logic                   w_mem_pend;
    logic                   w_freeze;
    logic                   w_grant;
    logic                   w_finish;
    logic                   w_write_req;
    logic                   w_unused_addr_bits;

    // Word addressing: the byte-lane bits and the bits above the SRAM are dropped.
    assign w_unused_addr_bits = ^{if_addr[31:SRAM_ADDR_W+2], if_addr[1:0],
                                  mem_addr[31:SRAM_ADDR_W+2], mem_addr[1:0]};

    assign w_mem_pend = (mem_r_en | mem_w_en) & ~r_mem_done;
    assign w_if_pend  = if_req & ~r_if_done;
    assign w_freeze   = w_if_pend | w_mem_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_mem_pend || w_if_pend) begin
                    w_next_state = c_st_access;
                end
            end
            c_st_access: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_write_req = w_mem_pend & mem_w_en;
        case (r_state)
            c_st_idle:   w_grant  = w_mem_pend | w_if_pend;
            c_st_access: w_finish = (r_cnt == 4'd0);
            default: begin
                w_grant  = 1'b0;
                w_finish = 1'b0;
            end
        endcase
    end

    // SRAM pins only move at ACCESS entry and exit; ready is a one-cycle pulse in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_grant_mem   <= 1'b0;
            r_is_write    <= 1'b0;
            r_if_rdata    <= 32'd0;
            r_mem_rdata   <= 32'd0;
            r_if_ready    <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= 32'd0;
            r_sram_we_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            if (w_grant) begin
                r_grant_mem   <= w_mem_pend;
                r_is_write    <= w_write_req;
                r_sram_addr   <= w_mem_pend ? mem_addr[SRAM_ADDR_W+1:2]
                                            : if_addr[SRAM_ADDR_W+1:2];
                r_sram_dq_out <= mem_wdata;
                r_cnt         <= c_cnt_load;
                r_sram_we_n   <= ~w_write_req;
                r_sram_oe_n   <= w_write_req;
            end else if (w_finish) begin
                r_sram_we_n <= 1'b1;
                r_sram_oe_n <= 1'b1;
                if (r_grant_mem) begin
                    r_mem_ready <= 1'b1;
                    if (!r_is_write) begin
                        r_mem_rdata <= sram_dq_in;
                    end
                end else begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= sram_dq_in;
                end
            end else if (r_state == c_st_access) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Completion wins over the advance-clear so a finished access is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
        end else begin
            if (!w_freeze) begin
                r_if_done  <= 1'b0;
                r_mem_done <= 1'b0;
            end
            if (w_finish) begin
                if (r_grant_mem) begin
                    r_mem_done <= 1'b1;
                end else begin
                    r_if_done <= 1'b1;
                end
            end
        end
    end

    assign freeze      = w_freeze;
    assign if_rdata    = r_if_rdata;
    assign if_ready    = r_if_ready;
    assign mem_rdata   = r_mem_rdata;
    assign mem_ready   = r_mem_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_we_n   = r_sram_we_n;
    assign sram_oe_n   = r_sram_oe_n;

endmodule
`default_nettype wire
